// File: rtl/scan_sequencer.sv
// Ping-period sequencer: transmit burst, blanked listen window with echo
// detection, then a ready/valid result report; optional angle sweep.
//
// state  | meaning
// IDLE   | waiting for enable_in
// BURST  | transmitter active, period count 0..BURST_CYCLES-1
// LISTEN | receive window until count PERIOD_CYCLES-1
// REPORT | result_valid_out held until consumer accepts
module scan_sequencer #(
    parameter int BURST_CYCLES  = 524288,
    parameter int PERIOD_CYCLES = 16777216,
    parameter int BLANK_CYCLES  = 0,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int THRESHOLD     = 5000,
    parameter int HOLD_COUNT    = 1,
    parameter int ANGLE_WIDTH   = 8,
    parameter int ANGLE_MIN     = -30,
    parameter int ANGLE_MAX     = 30,
    parameter int ANGLE_STEP    = 10
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   enable_in,
    input  logic                                   mode_in,
    input  logic signed [ANGLE_WIDTH-1:0]          static_angle_in,
    input  logic [SAMPLE_WIDTH-1:0]                sample_in,
    input  logic                                   sample_valid_in,
    input  logic                                   result_ready_in,
    output logic                                   burst_out,
    output logic                                   burst_start_out,
    output logic                                   listen_out,
    output logic signed [ANGLE_WIDTH-1:0]          beam_angle_out,
    output logic                                   result_valid_out,
    output logic signed [ANGLE_WIDTH-1:0]          result_angle_out,
    output logic [$clog2(PERIOD_CYCLES)-1:0]       result_tof_out,
    output logic                                   result_hit_out,
    output logic                                   busy_out
);

    localparam int CW = $clog2(PERIOD_CYCLES);
    localparam int RW = (HOLD_COUNT > 1) ? $clog2(HOLD_COUNT) : 1;

    localparam logic [CW-1:0] LAST_BURST = CW'(BURST_CYCLES - 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] ARM_COUNT  = CW'(BURST_CYCLES + BLANK_CYCLES);
    localparam logic [RW-1:0] RUN_LAST   = RW'(HOLD_COUNT - 1);
    localparam logic [SAMPLE_WIDTH-1:0] THR = SAMPLE_WIDTH'(THRESHOLD);

    localparam logic signed [ANGLE_WIDTH-1:0] A_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
    localparam logic signed [ANGLE_WIDTH-1:0] A_STEP = ANGLE_WIDTH'(ANGLE_STEP);
    localparam logic signed [ANGLE_WIDTH-1:0] A_WRAP = ANGLE_WIDTH'(ANGLE_MAX - ANGLE_STEP);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BURST  = 2'd1,
        LISTEN = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]                 count;
    logic [CW-1:0]                 tof;
    logic [RW-1:0]                 run;
    logic                          hit;
    logic signed [ANGLE_WIDTH-1:0] sweep_ptr;
    logic signed [ANGLE_WIDTH-1:0] sweep_adv;
    logic signed [ANGLE_WIDTH-1:0] ptr_next;
    logic signed [ANGLE_WIDTH-1:0] beam_angle;
    logic                          start_burst;
    logic                          handshake;
    logic                          armed;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        start_burst      = 1'b0;
        burst_out        = 1'b0;
        burst_start_out  = 1'b0;
        listen_out       = 1'b0;
        result_valid_out = 1'b0;
        busy_out         = 1'b0;
        case (state)
            IDLE: begin
                if (enable_in) begin
                    state_next  = BURST;
                    start_burst = 1'b1;
                end
            end
            BURST: begin
                busy_out        = 1'b1;
                burst_out       = 1'b1;
                burst_start_out = (count == '0);
                if (count == LAST_BURST) begin
                    state_next = LISTEN;
                end
            end
            LISTEN: begin
                busy_out   = 1'b1;
                listen_out = 1'b1;
                if (count == LAST_COUNT) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                busy_out         = 1'b1;
                result_valid_out = 1'b1;
                if (result_ready_in) begin
                    if (enable_in) begin
                        state_next  = BURST;
                        start_burst = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign handshake = (state == REPORT) && result_ready_in;
    assign armed     = (state == LISTEN) && (count >= ARM_COUNT) && !hit;
    assign sweep_adv = (sweep_ptr > A_WRAP) ? A_MIN : sweep_ptr + A_STEP;

    // Leaving IDLE restarts the sweep; an accepted sweep result advances it,
    // so a back-to-back burst already sees the advanced angle.
    always_comb begin
        ptr_next = sweep_ptr;
        if (state == IDLE && start_burst) begin
            ptr_next = A_MIN;
        end else if (handshake && mode_in) begin
            ptr_next = sweep_adv;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count      <= '0;
            tof        <= '0;
            run        <= '0;
            hit        <= 1'b0;
            sweep_ptr  <= A_MIN;
            beam_angle <= '0;
        end else begin
            sweep_ptr <= ptr_next;
            if (start_burst) begin
                count      <= '0;
                tof        <= '0;
                run        <= '0;
                hit        <= 1'b0;
                beam_angle <= mode_in ? ptr_next : static_angle_in;
            end else if (state == BURST || state == LISTEN) begin
                count <= count + 1'b1;
                if (armed && sample_valid_in) begin
                    if (sample_in > THR) begin
                        if (run == RUN_LAST) begin
                            hit <= 1'b1;
                            tof <= count;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end else begin
                        run <= '0;
                    end
                end
            end
        end
    end

    assign beam_angle_out   = beam_angle;
    assign result_angle_out = beam_angle;
    assign result_tof_out   = tof;
    assign result_hit_out   = hit;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: directed periods drive samples by period count;
// a scoreboard queue holds expected results checked by a separate monitor.
module tb_scan_sequencer;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              enable_in;
    logic              mode_in;
    logic signed [7:0] static_angle_in;
    logic [15:0]       sample_in;
    logic              sample_valid_in;
    logic              result_ready_in;
    logic              burst_out;
    logic              burst_start_out;
    logic              listen_out;
    logic signed [7:0] beam_angle_out;
    logic              result_valid_out;
    logic signed [7:0] result_angle_out;
    logic [4:0]        result_tof_out;
    logic              result_hit_out;
    logic              busy_out;

    always #5 clk_in = ~clk_in;

    scan_sequencer #(
        .BURST_CYCLES (4),
        .PERIOD_CYCLES(32),
        .BLANK_CYCLES (2),
        .SAMPLE_WIDTH (16),
        .THRESHOLD    (100),
        .HOLD_COUNT   (2),
        .ANGLE_WIDTH  (8),
        .ANGLE_MIN    (-30),
        .ANGLE_MAX    (30),
        .ANGLE_STEP   (10)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .enable_in       (enable_in),
        .mode_in         (mode_in),
        .static_angle_in (static_angle_in),
        .sample_in       (sample_in),
        .sample_valid_in (sample_valid_in),
        .result_ready_in (result_ready_in),
        .burst_out       (burst_out),
        .burst_start_out (burst_start_out),
        .listen_out      (listen_out),
        .beam_angle_out  (beam_angle_out),
        .result_valid_out(result_valid_out),
        .result_angle_out(result_angle_out),
        .result_tof_out  (result_tof_out),
        .result_hit_out  (result_hit_out),
        .busy_out        (busy_out)
    );

    typedef struct {
        int angle;
        int tof;
        int hit;
    } res_t;

    res_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   stim_val[32];
    bit   stim_vld[32];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: results are compared when accepted; fields must hold during stalls.
    int held_angle, held_tof, held_hit;
    bit held = 1'b0;
    always @(negedge clk_in) begin
        res_t e;
        #1;
        if (result_valid_out) begin
            if (held) begin
                chk("stall_angle", int'(result_angle_out), held_angle);
                chk("stall_tof", int'(result_tof_out), held_tof);
                chk("stall_hit", int'(result_hit_out), held_hit);
            end else begin
                held_angle = int'(result_angle_out);
                held_tof   = int'(result_tof_out);
                held_hit   = int'(result_hit_out);
                held       = 1'b1;
            end
            if (result_ready_in) begin
                held = 1'b0;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: unexpected result angle %0d tof %0d",
                             result_angle_out, result_tof_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("res_angle", int'(result_angle_out), e.angle);
                    chk("res_tof", int'(result_tof_out), e.tof);
                    chk("res_hit", int'(result_hit_out), e.hit);
                end
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic clear_stim();
        for (int i = 0; i < 32; i++) begin
            stim_val[i] = 0;
            stim_vld[i] = 1'b0;
        end
    endtask

    task automatic set_stim(input int k, input int v);
        stim_val[k] = v;
        stim_vld[k] = 1'b1;
    endtask

    task automatic wait_burst_start(output int w);
        w = 0;
        do begin
            @(negedge clk_in);
            w++;
        end while (!burst_start_out && w < 100);
    endtask

    // Runs one full period from its burst_start and returns on the first REPORT cycle.
    task automatic run_period(input int exp_angle, input int exp_tof, input int exp_hit,
                              input int exp_wait, input int drop_en_at, input bit hold_ready);
        int w;
        wait_burst_start(w);
        if (!burst_start_out) begin
            chk("burst_timeout", 0, 1);
            return;
        end
        if (exp_wait > 0) chk("burst_gap", w, exp_wait);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) @(negedge clk_in);
            chk("burst_out", int'(burst_out), int'(k < 4));
            chk("listen_out", int'(listen_out), int'(k >= 4));
            chk("burst_start", int'(burst_start_out), int'(k == 0));
            chk("beam_angle", int'(beam_angle_out), exp_angle);
            chk("busy", int'(busy_out), 1);
            sample_in       = 16'(stim_val[k]);
            sample_valid_in = stim_vld[k];
            if (k == drop_en_at) enable_in = 1'b0;
            if (k == 31 && hold_ready) result_ready_in = 1'b0;
        end
        sb_q.push_back('{exp_angle, exp_tof, exp_hit});
        @(negedge clk_in);
        sample_in       = '0;
        sample_valid_in = 1'b0;
        chk("report_valid", int'(result_valid_out), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_burst"}, int'(burst_out), 0);
        chk({tag, "_start"}, int'(burst_start_out), 0);
        chk({tag, "_listen"}, int'(listen_out), 0);
        chk({tag, "_beam"}, int'(beam_angle_out), 0);
        chk({tag, "_valid"}, int'(result_valid_out), 0);
        chk({tag, "_angle"}, int'(result_angle_out), 0);
        chk({tag, "_tof"}, int'(result_tof_out), 0);
        chk({tag, "_hit"}, int'(result_hit_out), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    int sweep_ang[8] = '{-30, -20, -10, 0, 10, 20, 30, -30};

    initial begin
        int   w;
        res_t dropped;
        rst_in          = 1'b1;
        enable_in       = 1'b0;
        mode_in         = 1'b0;
        static_angle_in = '0;
        sample_in       = '0;
        sample_valid_in = 1'b0;
        result_ready_in = 1'b1;
        clear_stim();

        repeat (3) @(negedge clk_in);
        chk_all_zero("reset");
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("idle_busy", int'(busy_out), 0);

        // Static angle, echo at counts 10,11
        enable_in = 1'b1;
        set_stim(10, 150);
        set_stim(11, 150);
        run_period(0, 11, 1, 1, -1, 1'b0);

        // No echo
        clear_stim();
        static_angle_in = -15;
        run_period(-15, 0, 0, 1, -1, 1'b0);

        // Blanked sample, broken run, later echoes ignored
        clear_stim();
        static_angle_in = 7;
        set_stim(5, 150);
        set_stim(8, 150);
        set_stim(9, 90);
        set_stim(10, 150);
        set_stim(11, 150);
        set_stim(20, 150);
        set_stim(21, 150);
        run_period(7, 11, 1, 1, -1, 1'b0);

        // Burst/blank samples ignored, invalid sample does not break the run
        clear_stim();
        static_angle_in = 45;
        set_stim(3, 150);
        set_stim(4, 150);
        set_stim(5, 150);
        set_stim(12, 150);
        stim_val[13] = 150;
        set_stim(14, 150);
        run_period(45, 14, 1, 1, -1, 1'b0);

        // First armed count
        clear_stim();
        static_angle_in = -128;
        set_stim(6, 150);
        set_stim(7, 150);
        run_period(-128, 7, 1, 1, -1, 1'b0);

        // Threshold is exclusive; hit on the last period count
        clear_stim();
        static_angle_in = 127;
        set_stim(15, 150);
        set_stim(16, 100);
        set_stim(17, 101);
        set_stim(18, 100);
        set_stim(30, 101);
        set_stim(31, 65535);
        run_period(127, 31, 1, 1, -1, 1'b0);

        // Consumer stalls 5 REPORT cycles
        clear_stim();
        static_angle_in = 0;
        set_stim(25, 200);
        set_stim(26, 200);
        run_period(0, 26, 1, 1, -1, 1'b1);
        repeat (4) begin
            @(negedge clk_in);
            chk("stall_valid", int'(result_valid_out), 1);
            chk("stall_no_start", int'(burst_start_out), 0);
        end
        @(negedge clk_in);
        result_ready_in = 1'b1;

        // Enable dropped mid-LISTEN: one report, then IDLE
        clear_stim();
        static_angle_in = -5;
        run_period(-5, 0, 0, 1, 15, 1'b0);
        repeat (3) begin
            @(negedge clk_in);
            chk("idle_after_drop", int'(busy_out), 0);
            chk("idle_no_burst", int'(burst_out), 0);
            chk("idle_no_valid", int'(result_valid_out), 0);
        end

        // Sweep, back-to-back with ready high
        mode_in         = 1'b1;
        static_angle_in = 99;
        enable_in       = 1'b1;
        for (int i = 0; i < 8; i++) begin
            clear_stim();
            if (i % 2 == 1) begin
                set_stim(9 + i, 150);
                set_stim(10 + i, 150);
                run_period(sweep_ang[i], 10 + i, 1, 1, -1, 1'b0);
            end else begin
                run_period(sweep_ang[i], 0, 0, 1, -1, 1'b0);
            end
        end

        // Reset mid-LISTEN of the next sweep period
        clear_stim();
        wait_burst_start(w);
        chk("abort_start", int'(burst_start_out), 1);
        chk("abort_beam", int'(beam_angle_out), -20);
        repeat (12) @(negedge clk_in);
        chk("abort_listen", int'(listen_out), 1);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk_all_zero("mid_reset");
        rst_in = 1'b0;
        run_period(-30, 0, 0, 1, -1, 1'b0);

        // Reset mid-REPORT drops valid without a handshake
        clear_stim();
        set_stim(20, 150);
        set_stim(21, 150);
        run_period(-20, 21, 1, 1, -1, 1'b1);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rpt_reset_valid", int'(result_valid_out), 0);
        chk("rpt_reset_busy", int'(busy_out), 0);
        chk("rpt_reset_tof", int'(result_tof_out), 0);
        chk("rpt_reset_hit", int'(result_hit_out), 0);
        if (sb_q.size() > 0) dropped = sb_q.pop_back();
        enable_in       = 1'b0;
        rst_in          = 1'b0;
        result_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        chk("final_idle", int'(busy_out), 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
